ghr_ckpt_ctrl: RTL

//  Controls the speculative global history register used by the branch predictor.
//  - ID shifts in each predicted direction and checkpoints the pre-shift history per in-flight branch.
//  - On an out-of-order mispredict, the history is restored from the checkpoint, younger checkpoints
//    are squashed, and the actual direction is shifted in.
//  - Keeps an architectural copy updated at in-order commit; an exception flush falls back to it.

---
 rtl/ghr_ckpt_pkg.sv | 20 ++
 rtl/ghr_ckpt_ram.sv | 32 +++
 rtl/ghr_ckpt_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/ghr_ckpt_pkg.sv
// Shared branch-history definitions for the GHR checkpoint controller.
// Provides the history length, checkpoint depth/tag widths, the bus
// typedefs built from them, and the history shift helper.
package ghr_ckpt_pkg;

  localparam int unsigned GHR_WIDTH  = 5;
  localparam int unsigned CKPT_DEPTH = 8;
  localparam int unsigned CKPT_TAG_W = $clog2(CKPT_DEPTH);

  typedef logic [GHR_WIDTH-1:0]  ghr_bus_t;
  typedef logic [CKPT_TAG_W-1:0] ckpt_tag_t;
  // Pointer/count width carries one extra wrap bit to tell full from empty.
  typedef logic [CKPT_TAG_W:0]   ckpt_cnt_t;

  // Shift a direction into a history; callers pass only the bits that survive.
  function automatic ghr_bus_t ghr_push(input logic [GHR_WIDTH-2:0] keep, input logic dir);
    return {keep, dir};
  endfunction

endpackage

// File: rtl/ghr_ckpt_ram.sv
// Checkpoint storage: DEPTH x WIDTH flop array, one synchronous write port
// and one asynchronous read port. Contents are not reset.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational)
module ghr_ckpt_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ghr_ckpt_ctrl.sv
// Speculative global-history controller with per-branch checkpoints.
// ID shifts predictions into ghr_spec and checkpoints the pre-shift history;
// an EX mispredict restores from the checkpoint and squashes younger branches;
// commit maintains ghr_arch, which a flush copies back into ghr_spec.
//   clk, rst (sync, active-low)
//   pred_valid/pred_taken -> pred_ready, pred_tag   : ID prediction handshake
//   res_valid/res_tag/res_mispred/res_taken         : EX resolve
//   commit_valid/commit_taken                       : in-order retire
//   flush                                           : discard speculative state
//   ghr_spec, ghr_arch, ckpt_count                  : history / occupancy outputs
module ghr_ckpt_ctrl
  import ghr_ckpt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic                  pred_taken,
  output logic                  pred_ready,
  output logic [CKPT_TAG_W-1:0] pred_tag,
  input  logic                  res_valid,
  input  logic [CKPT_TAG_W-1:0] res_tag,
  input  logic                  res_mispred,
  input  logic                  res_taken,
  input  logic                  commit_valid,
  input  logic                  commit_taken,
  input  logic                  flush,
  output logic [GHR_WIDTH-1:0]  ghr_spec,
  output logic [GHR_WIDTH-1:0]  ghr_arch,
  output logic [CKPT_TAG_W:0]   ckpt_count
);

  localparam ckpt_cnt_t CNT_ONE  = ckpt_cnt_t'(1);
  localparam ckpt_cnt_t CNT_FULL = ckpt_cnt_t'(CKPT_DEPTH);

  ckpt_cnt_t head_q, head_d, tail_q, tail_d, count;
  ghr_bus_t  spec_q, spec_d, arch_q, arch_d;
  ckpt_tag_t res_off;
  logic      res_live, mispred, accept, push, commit_ok;
  // The checkpoint MSB is always shifted out on restore, so it is never stored.
  logic [GHR_WIDTH-2:0] ckpt_rd;

  ghr_ckpt_ram #(
    .DEPTH (CKPT_DEPTH),
    .WIDTH (GHR_WIDTH-1),
    .AW    (CKPT_TAG_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (tail_q[CKPT_TAG_W-1:0]),
    .wdata_i (spec_q[GHR_WIDTH-2:0]),
    .raddr_i (res_tag),
    .rdata_o (ckpt_rd)
  );

  always_comb begin
    count      = tail_q - head_q;
    pred_ready = (count != CNT_FULL);
    accept     = pred_valid & pred_ready;
    // Live iff the tag's distance from head is below the occupancy.
    res_off    = res_tag - head_q[CKPT_TAG_W-1:0];
    res_live   = ({1'b0, res_off} < count);
    mispred    = res_valid & res_mispred & res_live;
    commit_ok  = commit_valid & (count != '0);
    head_d     = head_q + ckpt_cnt_t'(commit_ok);
    arch_d     = commit_ok ? ghr_push(arch_q[GHR_WIDTH-2:0], commit_taken) : arch_q;
    // A prediction coincident with flush or mispredict is wrong-path.
    push       = accept & ~flush & ~mispred;
    spec_d     = spec_q;
    tail_d     = tail_q;
    if (flush) begin
      spec_d = arch_d;
      tail_d = head_d;
    end else if (mispred) begin
      spec_d = ghr_push(ckpt_rd, res_taken);
      tail_d = head_q + {1'b0, res_off} + CNT_ONE;
    end else if (push) begin
      spec_d = ghr_push(spec_q[GHR_WIDTH-2:0], pred_taken);
      tail_d = tail_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      spec_q <= '0;
      arch_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      spec_q <= spec_d;
      arch_q <= arch_d;
    end
  end

  assign pred_tag   = tail_q[CKPT_TAG_W-1:0];
  assign ghr_spec   = spec_q;
  assign ghr_arch   = arch_q;
  assign ckpt_count = count;

endmodule
